// File: rtl/tb_stats_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tb_stats_ctrl_pkg
// Shared definitions for the simulation stats control peripheral:
//   - register offsets inside the 16-byte window
//   - CTRL register bit positions (write side and read side)
//   - the read-only ID word ("STAT")
//   - print FSM state encoding
//   - byte-enable merge helper used by the MARK register
// ---------------------------------------------------------------------------
package tb_stats_ctrl_pkg;

   localparam logic [3:0] OFF_CTRL  = 4'h0;
   localparam logic [3:0] OFF_MARK  = 4'h4;
   localparam logic [3:0] OFF_CYCLE = 4'h8;
   localparam logic [3:0] OFF_ID    = 4'hC;

   // CTRL write bits
   localparam int CTRL_START_STOP_BIT = 0;
   localparam int CTRL_PRINT_BIT      = 1;

   // CTRL read bits
   localparam int CTRL_RD_COUNTING = 0;
   localparam int CTRL_RD_BUSY     = 1;
   localparam int CTRL_RD_PENDING  = 2;

   localparam logic [31:0] ID_VALUE = 32'h5354_4154;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } print_state_e;

   // Replace only the bytes whose enable is set.
   function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  be);
      logic [31:0] result;
      result = oldVal;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            result[b*8 +: 8] = newVal[b*8 +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/tb_stats_print_fsm.sv
// ---------------------------------------------------------------------------
// tb_stats_print_fsm
// Turns single-cycle print requests into print_req_o pulses of PrintHold
// cycles, separated by at least PrintGap low cycles. One request may be
// queued while a pulse or its gap is in progress; extra requests are dropped.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   req_i        one-cycle print request
//   print_req_o  print request level (high while in HIGH)
//   busy_o       FSM not idle
//   pending_o    a request is queued behind the current pulse
// ---------------------------------------------------------------------------
module tb_stats_print_fsm
   import tb_stats_ctrl_pkg::*;
#(
   parameter int unsigned PrintHold = 4,
   parameter int unsigned PrintGap  = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_i,
   output logic print_req_o,
   output logic busy_o,
   output logic pending_o
);

   localparam logic [7:0] HoldLoad = 8'(PrintHold - 1);
   localparam logic [7:0] GapLoad  = 8'(PrintGap - 1);

   print_state_e r_state;
   print_state_e w_stateNext;
   logic [7:0]   r_count;
   logic [7:0]   w_countNext;
   logic         r_pending;
   logic         w_pendingNext;
   logic         w_pendEff;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_count   <= w_countNext;
         r_pending <= w_pendingNext;
      end
   end

   // A request landing in the final GAP cycle is folded into w_pendEff so it
   // restarts HIGH directly instead of being parked behind an IDLE state.
   always_comb begin
      w_stateNext   = r_state;
      w_countNext   = r_count;
      w_pendingNext = r_pending;
      w_pendEff     = r_pending | req_i;
      case (r_state)
         IDLE: begin
            if (req_i) begin
               w_stateNext = HIGH;
               w_countNext = HoldLoad;
            end
         end
         HIGH: begin
            w_pendingNext = w_pendEff;
            if (r_count == 8'd0) begin
               w_stateNext = GAP;
               w_countNext = GapLoad;
            end else begin
               w_countNext = r_count - 8'd1;
            end
         end
         GAP: begin
            if (r_count == 8'd0) begin
               w_pendingNext = 1'b0;
               if (w_pendEff) begin
                  w_stateNext = HIGH;
                  w_countNext = HoldLoad;
               end else begin
                  w_stateNext = IDLE;
               end
            end else begin
               w_pendingNext = w_pendEff;
               w_countNext   = r_count - 8'd1;
            end
         end
         default: begin
            w_stateNext   = IDLE;
            w_countNext   = '0;
            w_pendingNext = 1'b0;
         end
      endcase
   end

   assign print_req_o = (r_state == HIGH);
   assign busy_o      = (r_state != IDLE);
   assign pending_o   = r_pending;

endmodule

// File: rtl/tb_stats_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stats_ctrl
// Memory-mapped control peripheral for the simulation stats collector.
// Register window (BaseAddr must be 16-byte aligned):
//   0x0 CTRL  W: bit0 start/stop toggle, bit1 print request
//             R: {29'b0, print_pending, print_busy, counting}
//   0x4 MARK  R/W, byte-enable aware
//   0x8 CYCLE R: cycle counter (runs while counting), W: clear
//   0xC ID    R: 32'h5354_4154, writes ignored
// Responses come one cycle after each grant, in order.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   data_req_i/gnt_o        bus request / combinational grant
//   data_we_i, data_be_i    write enable, byte enables
//   data_addr_i/wdata_i     byte address, write data
//   data_rvalid_o/rdata_o   registered response valid / read data
//   data_err_o              registered response error (misaligned)
//   start_stop_o            one-cycle toggle pulse to the collector
//   print_req_o             print request level
//   counting_o              mirror of the collector count enable
// ---------------------------------------------------------------------------
module tb_stats_ctrl
   import tb_stats_ctrl_pkg::*;
#(
   parameter logic [31:0] BaseAddr  = 32'h8000_0000,
   parameter int unsigned PrintHold = 4,
   parameter int unsigned PrintGap  = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        start_stop_o,
   output logic        print_req_o,
   output logic        counting_o
);

   logic        w_hit;
   logic        w_aligned;
   logic [3:0]  w_offset;
   logic        w_wr;
   logic        w_rd;
   logic        w_ctrlWr;
   logic        w_toggle;
   logic        w_printReq;
   logic        w_markWr;
   logic        w_cycleClr;
   logic        w_printBusy;
   logic        w_printPending;
   logic [31:0] w_rdataNext;

   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        r_startStop;
   logic        r_counting;
   logic [31:0] r_mark;
   logic [31:0] r_cycle;

   assign w_hit      = data_req_i & (data_addr_i[31:4] == BaseAddr[31:4]);
   assign data_gnt_o = w_hit;
   assign w_aligned  = (data_addr_i[1:0] == 2'b00);
   assign w_offset   = {data_addr_i[3:2], 2'b00};

   // Misaligned accesses and all-zero byte enables never touch state.
   assign w_wr       = w_hit & w_aligned & data_we_i & (data_be_i != 4'b0000);
   assign w_rd       = w_hit & w_aligned & ~data_we_i;
   assign w_ctrlWr   = w_wr & (w_offset == OFF_CTRL) & data_be_i[0];
   assign w_toggle   = w_ctrlWr & data_wdata_i[CTRL_START_STOP_BIT];
   assign w_printReq = w_ctrlWr & data_wdata_i[CTRL_PRINT_BIT];
   assign w_markWr   = w_wr & (w_offset == OFF_MARK);
   assign w_cycleClr = w_wr & (w_offset == OFF_CYCLE);

   // Read data is zero for writes, errors and idle cycles.
   always_comb begin
      w_rdataNext = '0;
      if (w_rd) begin
         case (w_offset)
            OFF_CTRL: begin
               w_rdataNext[CTRL_RD_COUNTING] = r_counting;
               w_rdataNext[CTRL_RD_BUSY]     = w_printBusy;
               w_rdataNext[CTRL_RD_PENDING]  = w_printPending;
            end
            OFF_MARK:  w_rdataNext = r_mark;
            OFF_CYCLE: w_rdataNext = r_cycle;
            OFF_ID:    w_rdataNext = ID_VALUE;
            default:   w_rdataNext = '0;
         endcase
      end
   end

   // Response pipeline: one response per grant, one cycle later.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= w_hit;
         r_rdata  <= w_rdataNext;
         r_err    <= w_hit & ~w_aligned;
      end
   end

   // The pulse and the local counting mirror change on the same edge so
   // counting_o always matches the consumer's enable.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_startStop <= 1'b0;
         r_counting  <= 1'b0;
      end else begin
         r_startStop <= w_toggle;
         r_counting  <= r_counting ^ w_toggle;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mark <= '0;
      end else if (w_markWr) begin
         r_mark <= mergeBytes(r_mark, data_wdata_i, data_be_i);
      end
   end

   // Clear takes priority over the increment.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cycle <= '0;
      end else if (w_cycleClr) begin
         r_cycle <= '0;
      end else if (r_counting) begin
         r_cycle <= r_cycle + 32'd1;
      end
   end

   tb_stats_print_fsm #(
      .PrintHold (PrintHold),
      .PrintGap  (PrintGap)
   ) u_printFsm (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (w_printReq),
      .print_req_o (print_req_o),
      .busy_o      (w_printBusy),
      .pending_o   (w_printPending)
   );

   assign data_rvalid_o = r_rvalid;
   assign data_rdata_o  = r_rdata;
   assign data_err_o    = r_err;
   assign start_stop_o  = r_startStop;
   assign counting_o    = r_counting;

endmodule

// File: tb/tb_tb_stats_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tb_stats_ctrl
// Self-checking bench for tb_stats_ctrl: a table of directed bus vectors,
// hand-written multi-cycle sequences (cycle counter, print pulses, reset
// during a pulse), and randomized bus traffic checked against a reference
// model built from register semantics and a list of pulse start times.
// ---------------------------------------------------------------------------
module tb_tb_stats_ctrl;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          HOLD  = 4;
   localparam int          GAPC  = 2;
   localparam logic [31:0] IDVAL = 32'h5354_4154;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        drvReq = 1'b0;
   logic        drvWe = 1'b0;
   logic [3:0]  drvBe = 4'h0;
   logic [31:0] drvAddr = 32'h0;
   logic [31:0] drvWdata = 32'h0;
   logic        gntO;
   logic        rvalidO;
   logic [31:0] rdataO;
   logic        errO;
   logic        startStopO;
   logic        printReqO;
   logic        countingO;

   int vecCount  = 0;
   int missCount = 0;
   int cycleNum  = 0;
   logic prTrace [0:1023];
   logic ssTrace [0:1023];

   // Reference model state
   logic [31:0] modelMark;
   logic        modelCounting;
   logic [31:0] modelAcc;
   int          modelRunStart;
   int          pulses[$];

   tb_stats_ctrl #(
      .BaseAddr  (BASE),
      .PrintHold (HOLD),
      .PrintGap  (GAPC)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rstN),
      .data_req_i    (drvReq),
      .data_gnt_o    (gntO),
      .data_we_i     (drvWe),
      .data_be_i     (drvBe),
      .data_addr_i   (drvAddr),
      .data_wdata_i  (drvWdata),
      .data_rvalid_o (rvalidO),
      .data_rdata_o  (rdataO),
      .data_err_o    (errO),
      .start_stop_o  (startStopO),
      .print_req_o   (printReqO),
      .counting_o    (countingO)
   );

   // Free-running clock and a cycle index used to timestamp grants
   always #5 clk = ~clk;
   always @(posedge clk) cycleNum <= cycleNum + 1;

   // Record output levels for each cycle, sampled mid-cycle
   always @(negedge clk) begin
      prTrace[cycleNum % 1024] = printReqO;
      ssTrace[cycleNum % 1024] = startStopO;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // One non-pipelined bus access: grant cycle, then response cycle.
   task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic gnt, output logic rvalid,
                                output logic [31:0] rdata, output logic err,
                                output int grantCycle);
      @(posedge clk);
      #1;
      drvReq = 1'b1; drvWe = we; drvAddr = addr; drvWdata = wdata; drvBe = be;
      grantCycle = cycleNum;
      @(negedge clk);
      gnt = gntO;
      @(posedge clk);
      #1;
      drvReq = 1'b0; drvWe = 1'b0; drvAddr = 32'h0; drvWdata = 32'h0; drvBe = 4'h0;
      @(negedge clk);
      rvalid = rvalidO; rdata = rdataO; err = errO;
   endtask

   // ---------------- reference model ----------------
   function automatic void modelReset();
      modelMark = 32'h0; modelCounting = 1'b0; modelAcc = 32'h0; modelRunStart = 0;
      pulses.delete();
   endfunction

   // Pulse timeline: a request starts a pulse the next cycle when idle, is
   // queued behind the current pulse+gap when busy, and is dropped if a
   // queued pulse already exists.
   function automatic void modelPrintReq(input int r);
      int p;
      if (pulses.size() == 0) begin
         pulses.push_back(r + 1);
      end else begin
         p = pulses[$];
         if (r < p) begin
            return;
         end else if (r <= p + HOLD + GAPC - 1) begin
            pulses.push_back(p + HOLD + GAPC);
         end else begin
            pulses.push_back(r + 1);
         end
      end
   endfunction

   function automatic logic prAt(input int c);
      foreach (pulses[i]) if (c >= pulses[i] && c < pulses[i] + HOLD) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic busyAt(input int c);
      foreach (pulses[i]) if (c >= pulses[i] && c <= pulses[i] + HOLD + GAPC - 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic pendingAt(input int c);
      foreach (pulses[i]) if (pulses[i] > c) return 1'b1;
      return 1'b0;
   endfunction

   // Counter value sampled by a read granted in cycle r
   function automatic logic [31:0] cycleAt(input int r);
      if (modelCounting) return modelAcc + 32'(r - modelRunStart);
      return modelAcc;
   endfunction

   function automatic logic [31:0] modelRead(input logic [3:0] off, input int r);
      case (off)
         4'h0:    return {29'b0, pendingAt(r), busyAt(r), modelCounting};
         4'h4:    return modelMark;
         4'h8:    return cycleAt(r);
         default: return IDVAL;
      endcase
   endfunction

   function automatic void modelApply(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] be,
                                      input int a);
      if (addr[31:4] != BASE[31:4] || addr[1:0] != 2'b00 || !we || be == 4'h0) return;
      case (addr[3:0])
         4'h0: begin
            if (be[0] && wdata[0]) begin
               if (modelCounting) begin
                  modelAcc = modelAcc + 32'(a + 1 - modelRunStart);
                  modelCounting = 1'b0;
               end else begin
                  modelCounting = 1'b1;
                  modelRunStart = a + 1;
               end
            end
            if (be[0] && wdata[1]) modelPrintReq(a);
         end
         4'h4: begin
            for (int b = 0; b < 4; b++) if (be[b]) modelMark[b*8 +: 8] = wdata[b*8 +: 8];
         end
         4'h8: begin
            modelAcc = 32'h0;
            modelRunStart = a + 1;
         end
         default: ;
      endcase
   endfunction

   // Bus access checked entirely against the model
   task automatic busOp(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      logic gnt, rvalid, err, expHit, expErr;
      logic [31:0] rdata, expData;
      int gc;
      applyStimulus(we, addr, wdata, be, gnt, rvalid, rdata, err, gc);
      expHit  = (addr[31:4] == BASE[31:4]);
      expErr  = expHit && (addr[1:0] != 2'b00);
      expData = (expHit && addr[1:0] == 2'b00 && !we) ? modelRead(addr[3:0], gc) : 32'h0;
      checkOutput($sformatf("gnt a=%08h", addr), {31'b0, gnt}, {31'b0, expHit});
      checkOutput($sformatf("rvalid a=%08h", addr), {31'b0, rvalid}, {31'b0, expHit});
      checkOutput($sformatf("err a=%08h", addr), {31'b0, err}, {31'b0, expErr});
      checkOutput($sformatf("rdata a=%08h we=%0b", addr, we), rdata, expData);
      modelApply(we, addr, wdata, be, gc);
   endtask

   task automatic checkTraceModel(input string name, input int fromC, input int toC);
      for (int c = fromC; c <= toC; c++)
         checkOutput($sformatf("%s c=%0d", name, c), {31'b0, prTrace[c % 1024]}, {31'b0, prAt(c)});
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        expGnt;
      logic        expErr;
      logic [31:0] expRdata;
   } vec_t;

   initial begin
      vec_t vecs [16];
      logic gnt, rvalid, err;
      logic [31:0] rdata, held;
      int gc, ga, gb;

      modelReset();
      vecs[0]  = '{1'b0, BASE + 32'hC, 32'h0,         4'hF, 1'b1, 1'b0, 32'h5354_4154};
      vecs[1]  = '{1'b0, BASE + 32'h0, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, BASE + 32'h4, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, BASE + 32'h8, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 4'h5, 1'b1, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, BASE + 32'h4, 32'h0,         4'hF, 1'b1, 1'b0, 32'h00AD_00EF};
      vecs[6]  = '{1'b0, BASE + 32'h1, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0};
      vecs[7]  = '{1'b0, BASE + 32'h10, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0};
      vecs[8]  = '{1'b1, BASE + 32'hC, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, BASE + 32'hC, 32'h0,         4'hF, 1'b1, 1'b0, 32'h5354_4154};
      vecs[10] = '{1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 32'h0};
      vecs[11] = '{1'b1, BASE + 32'h6, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0};
      vecs[12] = '{1'b0, BASE + 32'h4, 32'h0,         4'hF, 1'b1, 1'b0, 32'h00AD_00EF};
      vecs[13] = '{1'b1, BASE + 32'h4, 32'h1234_5678, 4'hA, 1'b1, 1'b0, 32'h0};
      vecs[14] = '{1'b0, BASE + 32'h4, 32'h0,         4'hF, 1'b1, 1'b0, 32'h12AD_56EF};
      vecs[15] = '{1'b0, BASE - 32'h4, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0};

      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("reset gnt", {31'b0, gntO}, 32'h0);
      checkOutput("reset rvalid", {31'b0, rvalidO}, 32'h0);
      checkOutput("reset rdata", rdataO, 32'h0);
      checkOutput("reset err", {31'b0, errO}, 32'h0);
      checkOutput("reset start_stop", {31'b0, startStopO}, 32'h0);
      checkOutput("reset print_req", {31'b0, printReqO}, 32'h0);
      checkOutput("reset counting", {31'b0, countingO}, 32'h0);

      // ---- directed table ----
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                       gnt, rvalid, rdata, err, gc);
         checkOutput($sformatf("vec%0d gnt", i), {31'b0, gnt}, {31'b0, vecs[i].expGnt});
         checkOutput($sformatf("vec%0d rvalid", i), {31'b0, rvalid}, {31'b0, vecs[i].expGnt});
         checkOutput($sformatf("vec%0d err", i), {31'b0, err}, {31'b0, vecs[i].expErr});
         checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].expRdata);
         modelApply(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, gc);
      end

      // ---- start/stop and cycle counter ----
      applyStimulus(1'b1, BASE, 32'h1, 4'hF, gnt, rvalid, rdata, err, ga);
      modelApply(1'b1, BASE, 32'h1, 4'hF, ga);
      checkOutput("start_stop in grant cycle", {31'b0, ssTrace[ga % 1024]}, 32'h0);
      checkOutput("start_stop after grant", {31'b0, startStopO}, 32'h1);
      checkOutput("counting on", {31'b0, countingO}, 32'h1);
      @(negedge clk);
      checkOutput("start_stop one cycle only", {31'b0, startStopO}, 32'h0);
      repeat (98) @(posedge clk);
      applyStimulus(1'b0, BASE + 32'h8, 32'h0, 4'hF, gnt, rvalid, rdata, err, gc);
      checkOutput("cycle after 100", rdata, 32'd100);
      checkOutput("cycle model", rdata, modelRead(4'h8, gc));
      applyStimulus(1'b1, BASE, 32'h1, 4'hF, gnt, rvalid, rdata, err, gb);
      modelApply(1'b1, BASE, 32'h1, 4'hF, gb);
      checkOutput("counting off", {31'b0, countingO}, 32'h0);
      busOp(1'b0, BASE + 32'h8, 32'h0, 4'hF);
      held = modelRead(4'h8, gb + 20);
      repeat (20) @(posedge clk);
      applyStimulus(1'b0, BASE + 32'h8, 32'h0, 4'hF, gnt, rvalid, rdata, err, gc);
      checkOutput("cycle frozen", rdata, held);

      // ---- single print pulse ----
      applyStimulus(1'b1, BASE, 32'h2, 4'hF, gnt, rvalid, rdata, err, ga);
      modelApply(1'b1, BASE, 32'h2, 4'hF, ga);
      applyStimulus(1'b0, BASE, 32'h0, 4'hF, gnt, rvalid, rdata, err, gc);
      checkOutput("ctrl during pulse", rdata, 32'h2);
      repeat (12) @(posedge clk);
      for (int k = 0; k <= 12; k++)
         checkOutput($sformatf("single pulse +%0d", k), {31'b0, prTrace[(ga + k) % 1024]},
                     (k >= 1 && k <= 4) ? 32'h1 : 32'h0);

      // ---- three back-to-back print requests ----
      @(posedge clk);
      #1;
      ga = cycleNum;
      for (int k = 0; k < 3; k++) begin
         drvReq = 1'b1; drvWe = 1'b1; drvAddr = BASE; drvWdata = 32'h2; drvBe = 4'hF;
         modelApply(1'b1, BASE, 32'h2, 4'hF, cycleNum);
         @(posedge clk);
         #1;
         checkOutput($sformatf("b2b rvalid %0d", k), {31'b0, rvalidO}, 32'h1);
      end
      drvReq = 1'b0; drvWe = 1'b0; drvAddr = 32'h0; drvWdata = 32'h0; drvBe = 4'h0;
      repeat (20) @(posedge clk);
      for (int k = 0; k <= 18; k++)
         checkOutput($sformatf("b2b pulse +%0d", k), {31'b0, prTrace[(ga + k) % 1024]},
                     ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) ? 32'h1 : 32'h0);

      // ---- simultaneous start/stop + print, then reset mid-pulse ----
      applyStimulus(1'b1, BASE, 32'h3, 4'hF, gnt, rvalid, rdata, err, ga);
      checkOutput("both start_stop", {31'b0, startStopO}, 32'h1);
      checkOutput("both print_req", {31'b0, printReqO}, 32'h1);
      checkOutput("both counting", {31'b0, countingO}, 32'h1);
      @(posedge clk);
      #1;
      drvReq = 1'b1; drvWe = 1'b0; drvAddr = BASE + 32'hC; drvBe = 4'hF;
      #2;
      checkOutput("print_req before reset", {31'b0, printReqO}, 32'h1);
      rstN = 1'b0;
      #1;
      checkOutput("async print_req drop", {31'b0, printReqO}, 32'h0);
      checkOutput("async start_stop", {31'b0, startStopO}, 32'h0);
      checkOutput("async counting drop", {31'b0, countingO}, 32'h0);
      @(negedge clk);
      checkOutput("in-flight discarded", {31'b0, rvalidO}, 32'h0);
      drvReq = 1'b0; drvAddr = 32'h0; drvBe = 4'h0;
      @(negedge clk);
      rstN = 1'b1;
      modelReset();
      applyStimulus(1'b1, BASE, 32'h2, 4'hF, gnt, rvalid, rdata, err, ga);
      modelApply(1'b1, BASE, 32'h2, 4'hF, ga);
      repeat (12) @(posedge clk);
      for (int k = 0; k <= 10; k++)
         checkOutput($sformatf("post-reset pulse +%0d", k), {31'b0, prTrace[(ga + k) % 1024]},
                     (k >= 1 && k <= 4) ? 32'h1 : 32'h0);
      busOp(1'b0, BASE + 32'h8, 32'h0, 4'hF);
      busOp(1'b0, BASE + 32'h4, 32'h0, 4'hF);

      // ---- randomized bus traffic ----
      for (int n = 0; n < 80; n++) begin
         int sel, off;
         logic we;
         logic [3:0] be;
         logic [31:0] addr;
         sel  = $urandom_range(0, 9);
         off  = 4 * $urandom_range(0, 3);
         if (sel == 0)      addr = BASE + 32'h10 + 32'(off);
         else if (sel == 1) addr = BASE + 32'(off) + 32'($urandom_range(1, 3));
         else               addr = BASE + 32'(off);
         we = 1'($urandom_range(0, 1));
         be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         busOp(we, addr, $urandom, be);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // ---- randomized pipelined print requests ----
      @(posedge clk);
      #1;
      ga = cycleNum;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            drvReq = 1'b1; drvWe = 1'b1; drvAddr = BASE; drvWdata = 32'h2; drvBe = 4'hF;
            modelApply(1'b1, BASE, 32'h2, 4'hF, cycleNum);
         end else begin
            drvReq = 1'b0; drvWe = 1'b0; drvAddr = 32'h0; drvWdata = 32'h0; drvBe = 4'h0;
         end
         @(posedge clk);
         #1;
      end
      drvReq = 1'b0; drvWe = 1'b0; drvAddr = 32'h0; drvWdata = 32'h0; drvBe = 4'h0;
      gb = cycleNum;
      repeat (30) @(posedge clk);
      checkTraceModel("random pulses", ga, gb + 25);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
